// File: rtl/alu_sequencer.sv
// Command front-end for the datapath ALU: accepts a command, sequences the operand loads,
// captures the settled result and flags, then presents them on a response handshake.
module alu_sequencer #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [3:0]         cmd_a,
  input  logic [3:0]         cmd_b,
  input  logic               cmd_chain,
  output logic [3:0]         dp_operand_a,
  output logic [3:0]         dp_operand_b,
  output logic [2:0]         dp_alu_op,
  output logic               dp_load_a,
  output logic               dp_load_b,
  input  logic [7:0]         dp_result,
  input  logic               dp_zero,
  input  logic               dp_carry,
  input  logic               dp_overflow,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [7:0]         rsp_result,
  output logic [2:0]         rsp_flags,
  output logic               busy,
  output logic [COUNT_W-1:0] cmd_count
);

  typedef enum logic [1:0] {StIdle, StLoad, StExec, StResp} state_e;

  state_e             state_q, state_d;
  logic [3:0]         a_q, a_d;
  logic [3:0]         b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [7:0]         result_q, result_d;
  logic [2:0]         flags_q, flags_d;
  logic [COUNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    count_d  = count_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          // Chain source is the last captured result, cleared by reset.
          a_d     = cmd_chain ? result_q[3:0] : cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          state_d = StLoad;
        end
      end
      StLoad: state_d = StExec;
      StExec: begin
        result_d = dp_result;
        flags_d  = {dp_overflow, dp_carry, dp_zero};
        state_d  = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          count_d = count_q + COUNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Every output comes straight from a register or a decode of the state.
  assign cmd_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign dp_load_a    = (state_q == StLoad);
  assign dp_load_b    = (state_q == StLoad);
  assign rsp_valid    = (state_q == StResp);
  assign dp_operand_a = a_q;
  assign dp_operand_b = b_q;
  assign dp_alu_op    = op_q;
  assign rsp_result   = result_q;
  assign rsp_flags    = flags_q;
  assign cmd_count    = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural datapath stand-in and a second
// instance at COUNT_W=2 to observe counter wrap.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       cmd_chain = 1'b0;
  logic [3:0] dp_operand_a, dp_operand_b;
  logic [2:0] dp_alu_op;
  logic       dp_load_a, dp_load_b;
  logic [7:0] dp_result;
  logic       dp_zero, dp_carry, dp_overflow;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_result;
  logic [2:0] rsp_flags;
  logic       busy;
  logic [7:0] cmd_count;

  logic       cmd_ready2, dp_load_a2, dp_load_b2, rsp_valid2, busy2;
  logic [3:0] dp_operand_a2, dp_operand_b2;
  logic [2:0] dp_alu_op2, rsp_flags2;
  logic [7:0] rsp_result2;
  logic [1:0] cmd_count2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .dp_operand_a(dp_operand_a), .dp_operand_b(dp_operand_b), .dp_alu_op(dp_alu_op),
    .dp_load_a(dp_load_a), .dp_load_b(dp_load_b), .dp_result(dp_result),
    .dp_zero(dp_zero), .dp_carry(dp_carry), .dp_overflow(dp_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .busy(busy), .cmd_count(cmd_count)
  );

  alu_sequencer #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .dp_operand_a(dp_operand_a2), .dp_operand_b(dp_operand_b2), .dp_alu_op(dp_alu_op2),
    .dp_load_a(dp_load_a2), .dp_load_b(dp_load_b2), .dp_result(dp_result),
    .dp_zero(dp_zero), .dp_carry(dp_carry), .dp_overflow(dp_overflow),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
    .rsp_flags(rsp_flags2), .busy(busy2), .cmd_count(cmd_count2)
  );

  // Datapath stand-in: operand registers loaded on load_a/load_b, combinational ALU.
  logic [3:0] dpa_q = '0;
  logic [3:0] dpb_q = '0;
  logic [3:0] bb;
  logic [4:0] sum5;

  always @(posedge clk) begin
    if (dp_load_a) dpa_q <= dp_operand_a;
    if (dp_load_b) dpb_q <= dp_operand_b;
  end

  always_comb begin
    bb          = (dp_alu_op == 3'b001) ? ~dpb_q : dpb_q;
    sum5        = {1'b0, dpa_q} + {1'b0, bb} + {4'b0, (dp_alu_op == 3'b001)};
    dp_result   = {4'b0, sum5[3:0]};
    dp_carry    = sum5[4];
    dp_zero     = (sum5[3:0] == 4'h0);
    dp_overflow = (dpa_q[3] == bb[3]) && (sum5[3] != dpa_q[3]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full command; with hold set, the response is backpressured for 10 cycles while a
  // competing command is offered.
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic chain, input logic [3:0] exp_a,
                         input logic [7:0] exp_r, input logic [2:0] exp_f,
                         input logic [7:0] exp_cnt, input bit hold);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    check({name, ".ready_idle"}, cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({name, ".ready_fall"}, cmd_ready, 0);
    check({name, ".load"}, {dp_load_a, dp_load_b}, 2'b11);
    check({name, ".opa"}, dp_operand_a, exp_a);
    check({name, ".opb"}, dp_operand_b, b);
    if (hold) rsp_ready = 1'b0;
    @(posedge clk); #1;
    check({name, ".exec_noload"}, {dp_load_a, dp_load_b}, 2'b00);
    check({name, ".exec_novalid"}, rsp_valid, 0);
    @(posedge clk); #1;
    check({name, ".rsp_valid"}, rsp_valid, 1);
    check({name, ".result"}, rsp_result, exp_r);
    check({name, ".flags"}, rsp_flags, exp_f);
    check({name, ".op_held"}, dp_alu_op, op);
    if (hold) begin
      cmd_valid = 1'b1; cmd_op = 3'b001; cmd_a = 4'hF; cmd_b = 4'hF; cmd_chain = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        check({name, ".bp_valid"}, rsp_valid, 1);
        check({name, ".bp_result"}, rsp_result, exp_r);
        check({name, ".bp_ready"}, cmd_ready, 0);
      end
      check({name, ".bp_count"}, cmd_count, exp_cnt - 8'd1);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({name, ".done_valid"}, rsp_valid, 0);
    check({name, ".done_ready"}, cmd_ready, 1);
    check({name, ".count"}, cmd_count, exp_cnt);
    check({name, ".count2"}, cmd_count2, exp_cnt[1:0]);
    check({name, ".result_kept"}, rsp_result, exp_r);
  endtask

  initial begin
    #12;
    check("reset.ready", cmd_ready, 1);
    check("reset.busy", busy, 0);
    check("reset.valid", rsp_valid, 0);
    check("reset.count", cmd_count, 0);
    check("reset.dp", {dp_operand_a, dp_operand_b, dp_alu_op, dp_load_a, dp_load_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //      name      op      a      b     ch    expA   result  flags   cnt  hold
    run_cmd("add53",  3'b000, 4'h5, 4'h3, 1'b0, 4'h5, 8'h08, 3'b100, 8'd1, 1'b0);
    run_cmd("sub35",  3'b001, 4'h3, 4'h5, 1'b0, 4'h3, 8'h0E, 3'b000, 8'd2, 1'b0);
    run_cmd("add71",  3'b000, 4'h7, 4'h1, 1'b0, 4'h7, 8'h08, 3'b100, 8'd3, 1'b0);
    run_cmd("chain",  3'b000, 4'h9, 4'h4, 1'b1, 4'h8, 8'h0C, 3'b000, 8'd4, 1'b0);
    run_cmd("addF1",  3'b000, 4'hF, 4'h1, 1'b0, 4'hF, 8'h00, 3'b011, 8'd5, 1'b0);
    run_cmd("bp",     3'b000, 4'h2, 4'h3, 1'b0, 4'h2, 8'h05, 3'b000, 8'd6, 1'b1);

    // Reset during EXEC aborts the command.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 4'h6; cmd_b = 4'h6; cmd_chain = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("abort.in_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort.ready", cmd_ready, 1);
    check("abort.busy", busy, 0);
    check("abort.valid", rsp_valid, 0);
    check("abort.rsp", {rsp_result, rsp_flags}, 0);
    check("abort.count", cmd_count, 0);
    check("abort.count2", cmd_count2, 0);
    check("abort.dp", {dp_operand_a, dp_operand_b, dp_alu_op, dp_load_a, dp_load_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd("chain0", 3'b000, 4'h9, 4'h4, 1'b1, 4'h0, 8'h04, 3'b000, 8'd1, 1'b0);
    run_cmd("add11",  3'b000, 4'h1, 4'h1, 1'b0, 4'h1, 8'h02, 3'b000, 8'd2, 1'b0);
    run_cmd("sub01",  3'b001, 4'h0, 4'h1, 1'b0, 4'h0, 8'h0F, 3'b000, 8'd3, 1'b0);
    run_cmd("add88",  3'b000, 4'h8, 4'h8, 1'b0, 4'h8, 8'h00, 3'b111, 8'd4, 1'b0);
    run_cmd("add44",  3'b000, 4'h4, 4'h4, 1'b0, 4'h4, 8'h08, 3'b100, 8'd5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
